// File: rtl/cpu_core_p.sv
// Parametrised five-stage (waits/fetcha/fetchb/execa/execb) CPU core driving a synchronous single-port RAM.
// Optional debug port and retired-instruction counter enabled by defining CPU_DBG_EN.
module cpu_core_p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              halt,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              rden,
  output logic              wren,
  output logic              waits,
  output logic              fetcha,
  output logic              fetchb,
  output logic              execa,
  output logic              execb,
  output logic [ADDR_W-1:0] pc_out,
  output logic              cflag,
  output logic              zflag
`ifdef CPU_DBG_EN
  ,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       retired
`endif
);

  typedef enum logic [2:0] {S_WAITS, S_FETCHA, S_FETCHB, S_EXECA, S_EXECB} stage_t;

  localparam logic [DATA_W:0] ONE = (DATA_W+1)'(1);

  stage_t                  stage, stage_nxt;
  logic [ADDR_W-1:0]       pc;
  logic [DATA_W-1:0]       ir_a, ir_b;
  logic [7:0][DATA_W-1:0]  regs;

  logic [7:0] opc;
  logic [2:0] g, d, ra, rb;
  logic [1:0] s;
  logic       is_hlt, is_ld, is_st, is_jgrp, is_alu, jmp_take;

  assign opc     = ir_a[7:0];
  assign g       = opc[7:5];
  assign s       = opc[4:3];
  assign d       = opc[2:0];
  assign ra      = ir_b[7:5];
  assign rb      = ir_b[4:2];
  assign is_hlt  = (opc == 8'h00);
  assign is_ld   = (g == 3'b000) && (s == 2'b01);
  assign is_st   = (g == 3'b000) && (s == 2'b10);
  assign is_jgrp = (g == 3'b001) && (s == 2'b11);
  assign is_alu  = (g == 3'b100);

  // Only the low byte of ir_a and the register fields of ir_b are decoded.
  logic unused_bits;
  assign unused_bits = ^{ir_a, ir_b};

  always_comb begin
    jmp_take = 1'b0;
    if (is_jgrp) begin
      case (d)
        3'b000:  jmp_take = cflag;
        3'b001:  jmp_take = !cflag;
        3'b010:  jmp_take = zflag;
        3'b011:  jmp_take = !zflag;
        3'b111:  jmp_take = 1'b1;
        default: jmp_take = 1'b0;
      endcase
    end
  end

  // One extra bit captures carry-out on add and borrow on subtract.
  logic [DATA_W:0]   alu_full;
  logic [DATA_W-1:0] op_a, op_b;
  assign op_a = regs[ra];
  assign op_b = regs[rb];

  always_comb begin
    case (s)
      2'b00:   alu_full = {1'b0, op_a} + ONE;
      2'b01:   alu_full = {1'b0, op_a} - ONE;
      2'b10:   alu_full = {1'b0, op_a} + {1'b0, op_b};
      default: alu_full = {1'b0, op_a} - {1'b0, op_b};
    endcase
  end

  always_comb begin
    stage_nxt = stage;
    case (stage)
      S_WAITS:  if (run) stage_nxt = S_FETCHA;
      S_FETCHA: stage_nxt = S_FETCHB;
      S_FETCHB: stage_nxt = S_EXECA;
      S_EXECA:  stage_nxt = S_EXECB;
      S_EXECB:  stage_nxt = (halt || is_hlt) ? S_WAITS : S_FETCHA;
      default:  stage_nxt = S_WAITS;
    endcase
  end

  // RAM strobes are purely a function of stage so reset kills them at once.
  always_comb begin
    addr  = '0;
    wdata = '0;
    rden  = 1'b0;
    wren  = 1'b0;
    case (stage)
      S_FETCHA, S_FETCHB: begin
        addr = pc;
        rden = 1'b1;
      end
      S_EXECA: begin
        if (is_ld) begin
          addr = rdata[ADDR_W-1:0];
          rden = 1'b1;
        end else if (is_st) begin
          addr  = rdata[ADDR_W-1:0];
          wdata = regs[d];
          wren  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage <= S_WAITS;
      pc    <= '0;
      ir_a  <= '0;
      ir_b  <= '0;
      regs  <= '0;
      cflag <= 1'b0;
      zflag <= 1'b0;
    end else begin
      stage <= stage_nxt;
      case (stage)
        S_FETCHA: pc <= pc + ADDR_W'(1);
        S_FETCHB: begin
          ir_a <= rdata;
          pc   <= pc + ADDR_W'(1);
        end
        S_EXECA: begin
          ir_b <= rdata;
          if (jmp_take) pc <= rdata[ADDR_W-1:0];
        end
        S_EXECB: begin
          if (is_ld) regs[d] <= rdata;
          else if (is_alu) begin
            regs[d] <= alu_full[DATA_W-1:0];
            cflag   <= alu_full[DATA_W];
            zflag   <= (alu_full[DATA_W-1:0] == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign waits  = (stage == S_WAITS);
  assign fetcha = (stage == S_FETCHA);
  assign fetchb = (stage == S_FETCHB);
  assign execa  = (stage == S_EXECA);
  assign execb  = (stage == S_EXECB);
  assign pc_out = pc;

`ifdef CPU_DBG_EN
  assign dbg_data = regs[dbg_sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) retired <= '0;
    else if (stage == S_EXECB) retired <= retired + 16'd1;
  end
`endif

endmodule
